// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and size/alignment helpers for the load/store controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef logic [3:0] be_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned sizes only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

  // Byte lane actually used: sub-size address bits are dropped for H and W.
  function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: return a;
      F3_H, F3_HU: return {a[1], 1'b0};
      default:     return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: return a[0];
      F3_W:        return a != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/ready bus between the load/store controller (master) and the L1 data cache (slave).
interface lsu_if #(
  parameter int ADDR_W = 15,
  parameter int N      = 32
);
  import lsu_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [N-1:0]      wdata;
  be_t               be;
  logic [N-1:0]      rdata;
  logic              ready;

  modport master (output req, we, address, wdata, be, input rdata, ready);
  modport slave  (input req, we, address, wdata, be, output rdata, ready);

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication with byte enables, and load lane extraction
// with sign/zero extension. Offsets arrive already reduced to the access size.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] store_data_i,
  output be_t         be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_ext_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    be_o    = '0;
    wdata_o = store_data_i;
    case (st_size_i)
      2'b00: begin
        be_o    = be_t'(4'b0001 << st_off_i);
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
      end
      2'b10:   be_o = 4'b1111;
      default: ;
    endcase
  end

  assign lane_b = rdata_i[{ld_off_i, 3'b000} +: 8];
  assign lane_h = rdata_i[{ld_off_i[1], 4'b0000} +: 16];

  always_comb begin
    load_ext_o = rdata_i;
    case (ld_funct3_i)
      F3_B:    load_ext_o = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_ext_o = {24'b0, lane_b};
      F3_H:    load_ext_o = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_ext_o = {16'b0, lane_h};
      default: load_ext_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: IDLE/WAIT/DONE handshake to the data cache with bounded wait.
// Define LSU_MISALIGN_TRAP_EN to abort misaligned halfword/word accesses instead of aligning them.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int n       = 32,
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_control,
  input  logic         store_control,
  input  logic [2:0]   funct3,
  input  logic [n-1:0] byte_addr,
  input  logic [n-1:0] store_data,
  output logic [n-1:0] load_data,
  output logic         stall,
  output logic         lsu_error,
  lsu_if.master        cache
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [n-1:0]      wdata_q, wdata_d;
  be_t               be_q, be_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [n-1:0]      ld_q, ld_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic         start, abort_req, misalign, timeout_hit, stall_c;
  logic [1:0]   st_off;
  be_t          st_be;
  logic [n-1:0] st_wdata, ld_ext;
  logic         unused_addr_hi;

  assign start  = load_control | store_control;
  assign st_off = lane_offset(funct3, byte_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = misaligned(funct3, byte_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign abort_req   = (load_control & store_control) | ~f3_legal(funct3, store_control) | misalign;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign unused_addr_hi = &{1'b0, byte_addr[n-1:ADDR_W+2]};

  lsu_align u_align (
    .st_size_i   (funct3[1:0]),
    .st_off_i    (st_off),
    .store_data_i(store_data),
    .be_o        (st_be),
    .wdata_o     (st_wdata),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .rdata_i     (cache.rdata),
    .load_ext_o  (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    off_d   = off_q;
    ld_d    = ld_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          stall_c = 1'b1;
          if (abort_req) begin
            state_d = DONE;
            ld_d    = '0;
            err_d   = 1'b1;
          end else begin
            state_d = WAIT;
            req_d   = 1'b1;
            we_d    = store_control;
            addr_d  = byte_addr[ADDR_W+1:2];
            wdata_d = st_wdata;
            be_d    = st_be;
            f3_d    = funct3;
            off_d   = st_off;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (cache.ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          ld_d    = we_q ? '0 : ld_ext;
        end else if (timeout_hit) begin
          state_d = DONE;
          req_d   = 1'b0;
          ld_d    = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of its neighbours.
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cache.req     = req_q;
  assign cache.we      = we_q;
  assign cache.address = addr_q;
  assign cache.wdata   = wdata_q;
  assign cache.be      = be_q;
  assign load_data     = ld_q;
  assign lsu_error     = err_q;
  // The decoder may still assert a memory op while reset is held; stall must stay low then.
  assign stall         = stall_c & ~reset;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl; a second instance with TIMEOUT=4 and ready tied low covers the timeout.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld, st, ld2, st2;
  logic [2:0]  f3;
  logic [31:0] baddr, sdata;
  logic [31:0] load_data, load_data2;
  logic        stall, stall2, lsu_error, err2;
  int          checks = 0;
  int          failures = 0;

  lsu_if #(.ADDR_W(15), .N(32)) cif ();
  lsu_if #(.ADDR_W(15), .N(32)) cif2 ();

  lsu_ctrl #(.n(32), .ADDR_W(15), .TIMEOUT(64)) u_dut (
    .clk(clk), .reset(reset), .load_control(ld), .store_control(st), .funct3(f3),
    .byte_addr(baddr), .store_data(sdata), .load_data(load_data), .stall(stall),
    .lsu_error(lsu_error), .cache(cif)
  );

  lsu_ctrl #(.n(32), .ADDR_W(15), .TIMEOUT(4)) u_dut_to (
    .clk(clk), .reset(reset), .load_control(ld2), .store_control(st2), .funct3(f3),
    .byte_addr(baddr), .store_data(sdata), .load_data(load_data2), .stall(stall2),
    .lsu_error(err2), .cache(cif2)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; ld = 1'b1; st = 1'b0; ld2 = 1'b0; st2 = 1'b0;
    f3 = 3'b000; baddr = 32'h103; sdata = 32'h0;
    cif.rdata = 32'h0; cif.ready = 1'b1;
    cif2.rdata = 32'hDEAD_BEEF; cif2.ready = 1'b0;
    repeat (2) @(posedge clk);
    sample();
    checks++; if (cif.req !== 1'b0) begin failures++; $display("FAIL rst_req got=%h exp=0", cif.req); end
    checks++; if (cif.we !== 1'b0) begin failures++; $display("FAIL rst_we got=%h exp=0", cif.we); end
    checks++; if (cif.address !== 15'h0) begin failures++; $display("FAIL rst_address got=%h exp=0", cif.address); end
    checks++; if (cif.wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", cif.wdata); end
    checks++; if (cif.be !== 4'h0) begin failures++; $display("FAIL rst_be got=%h exp=0", cif.be); end
    checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL rst_load_data got=%h exp=0", load_data); end
    checks++; if (lsu_error !== 1'b0) begin failures++; $display("FAIL rst_error got=%h exp=0", lsu_error); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%h exp=0", stall); end
    ld = 1'b0; cif.ready = 1'b0;
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_lb();
    ld = 1'b1; f3 = 3'b000; baddr = 32'h0000_0103; cif.rdata = 32'h80FF_0000; cif.ready = 1'b0;
    sample();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lb_c0_stall got=%h exp=1", stall); end
    checks++; if (cif.req !== 1'b0) begin failures++; $display("FAIL lb_c0_req got=%h exp=0", cif.req); end
    next_cycle(); cif.ready = 1'b1;
    sample();
    checks++; if (cif.req !== 1'b1) begin failures++; $display("FAIL lb_c1_req got=%h exp=1", cif.req); end
    checks++; if (cif.address !== 15'h40) begin failures++; $display("FAIL lb_c1_address got=%h exp=40", cif.address); end
    checks++; if (cif.we !== 1'b0) begin failures++; $display("FAIL lb_c1_we got=%h exp=0", cif.we); end
    next_cycle(); cif.ready = 1'b0;
    sample();
    checks++; if (load_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_c2_load_data got=%h exp=ffffff80", load_data); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lb_c2_stall got=%h exp=0", stall); end
    checks++; if (cif.req !== 1'b0) begin failures++; $display("FAIL lb_c2_req got=%h exp=0", cif.req); end
    checks++; if (lsu_error !== 1'b0) begin failures++; $display("FAIL lb_c2_error got=%h exp=0", lsu_error); end
    next_cycle(); ld = 1'b0;
    sample();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lb_c3_stall got=%h exp=0", stall); end
    next_cycle();
  endtask

  task automatic test_sh();
    st = 1'b1; f3 = 3'b001; baddr = 32'h0000_0012; sdata = 32'h0000_ABCD; cif.ready = 1'b0;
    sample();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sh_c0_stall got=%h exp=1", stall); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); cif.ready = (c == 3);
      sample();
      checks++; if (cif.req !== 1'b1) begin failures++; $display("FAIL sh_c%0d_req got=%h exp=1", c, cif.req); end
      checks++; if (cif.we !== 1'b1) begin failures++; $display("FAIL sh_c%0d_we got=%h exp=1", c, cif.we); end
      checks++; if (cif.be !== 4'b1100) begin failures++; $display("FAIL sh_c%0d_be got=%b exp=1100", c, cif.be); end
      checks++; if (cif.wdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_c%0d_wdata got=%h exp=abcdabcd", c, cif.wdata); end
      checks++; if (cif.address !== 15'h4) begin failures++; $display("FAIL sh_c%0d_address got=%h exp=4", c, cif.address); end
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sh_c%0d_stall got=%h exp=1", c, stall); end
    end
    next_cycle(); cif.ready = 1'b0;
    sample();
    checks++; if (cif.req !== 1'b0) begin failures++; $display("FAIL sh_done_req got=%h exp=0", cif.req); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sh_done_stall got=%h exp=0", stall); end
    checks++; if (lsu_error !== 1'b0) begin failures++; $display("FAIL sh_done_error got=%h exp=0", lsu_error); end
    st = 1'b0;
    next_cycle();
  endtask

  task automatic test_lhu();
    ld = 1'b1; f3 = 3'b101; baddr = 32'h0000_0002; cif.rdata = 32'hBEEF_0000; cif.ready = 1'b0;
    sample();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lhu_c0_stall got=%h exp=1", stall); end
    for (int c = 1; c <= 5; c++) begin
      next_cycle(); cif.ready = (c == 5);
      sample();
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lhu_c%0d_stall got=%h exp=1", c, stall); end
      checks++; if (cif.req !== 1'b1) begin failures++; $display("FAIL lhu_c%0d_req got=%h exp=1", c, cif.req); end
    end
    next_cycle(); cif.ready = 1'b0;
    sample();
    checks++; if (load_data !== 32'h0000_BEEF) begin failures++; $display("FAIL lhu_c6_load_data got=%h exp=0000beef", load_data); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lhu_c6_stall got=%h exp=0", stall); end
    ld = 1'b0;
    next_cycle();
  endtask

  task automatic test_timeout();
    ld2 = 1'b1; f3 = 3'b010; baddr = 32'h0000_0020;
    sample();
    checks++; if (stall2 !== 1'b1) begin failures++; $display("FAIL to_c0_stall got=%h exp=1", stall2); end
    checks++; if (cif2.req !== 1'b0) begin failures++; $display("FAIL to_c0_req got=%h exp=0", cif2.req); end
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      sample();
      checks++; if (cif2.req !== 1'b1) begin failures++; $display("FAIL to_c%0d_req got=%h exp=1", c, cif2.req); end
      checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL to_c%0d_error got=%h exp=0", c, err2); end
    end
    next_cycle();
    sample();
    checks++; if (err2 !== 1'b1) begin failures++; $display("FAIL to_c5_error got=%h exp=1", err2); end
    checks++; if (load_data2 !== 32'h0) begin failures++; $display("FAIL to_c5_load_data got=%h exp=0", load_data2); end
    checks++; if (cif2.req !== 1'b0) begin failures++; $display("FAIL to_c5_req got=%h exp=0", cif2.req); end
    checks++; if (stall2 !== 1'b0) begin failures++; $display("FAIL to_c5_stall got=%h exp=0", stall2); end
    next_cycle(); ld2 = 1'b0;
    sample();
    checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL to_c6_error got=%h exp=0", err2); end
    next_cycle();
  endtask

  task automatic test_abort();
    st = 1'b1; f3 = 3'b100; baddr = 32'h0000_0008; cif.ready = 1'b1;
    sample();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sbu_c0_stall got=%h exp=1", stall); end
    checks++; if (cif.req !== 1'b0) begin failures++; $display("FAIL sbu_c0_req got=%h exp=0", cif.req); end
    next_cycle();
    sample();
    checks++; if (cif.req !== 1'b0) begin failures++; $display("FAIL sbu_c1_req got=%h exp=0", cif.req); end
    checks++; if (lsu_error !== 1'b1) begin failures++; $display("FAIL sbu_c1_error got=%h exp=1", lsu_error); end
    checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL sbu_c1_load_data got=%h exp=0", load_data); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sbu_c1_stall got=%h exp=0", stall); end
    next_cycle(); ld = 1'b1; st = 1'b1; f3 = 3'b010;
    sample();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL both_c0_stall got=%h exp=1", stall); end
    next_cycle();
    sample();
    checks++; if (cif.req !== 1'b0) begin failures++; $display("FAIL both_c1_req got=%h exp=0", cif.req); end
    checks++; if (lsu_error !== 1'b1) begin failures++; $display("FAIL both_c1_error got=%h exp=1", lsu_error); end
    next_cycle(); ld = 1'b0; st = 1'b0; cif.ready = 1'b0;
    sample();
    checks++; if (lsu_error !== 1'b0) begin failures++; $display("FAIL both_c2_error got=%h exp=0", lsu_error); end
    next_cycle();
  endtask

  task automatic test_misalign();
    ld = 1'b1; f3 = 3'b010; baddr = 32'h0000_0105; cif.rdata = 32'h1234_5678; cif.ready = 1'b0;
    sample();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lw_mis_c0_stall got=%h exp=1", stall); end
    next_cycle(); cif.ready = 1'b1;
    sample();
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (cif.req !== 1'b0) begin failures++; $display("FAIL lw_mis_c1_req got=%h exp=0", cif.req); end
    checks++; if (lsu_error !== 1'b1) begin failures++; $display("FAIL lw_mis_c1_error got=%h exp=1", lsu_error); end
    checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL lw_mis_c1_load_data got=%h exp=0", load_data); end
    next_cycle(); ld = 1'b0; cif.ready = 1'b0;
`else
    checks++; if (cif.req !== 1'b1) begin failures++; $display("FAIL lw_mis_c1_req got=%h exp=1", cif.req); end
    checks++; if (cif.address !== 15'h41) begin failures++; $display("FAIL lw_mis_c1_address got=%h exp=41", cif.address); end
    checks++; if (lsu_error !== 1'b0) begin failures++; $display("FAIL lw_mis_c1_error got=%h exp=0", lsu_error); end
    next_cycle(); cif.ready = 1'b0;
    sample();
    checks++; if (load_data !== 32'h1234_5678) begin failures++; $display("FAIL lw_mis_c2_load_data got=%h exp=12345678", load_data); end
    checks++; if (lsu_error !== 1'b0) begin failures++; $display("FAIL lw_mis_c2_error got=%h exp=0", lsu_error); end
    ld = 1'b0;
`endif
    next_cycle();
  endtask

  task automatic test_back_to_back();
    cif.ready = 1'b1; st = 1'b1; f3 = 3'b000; baddr = 32'h0000_0001; sdata = 32'h0000_00A5;
    sample();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_sb_c0_stall got=%h exp=1", stall); end
    next_cycle();
    sample();
    checks++; if (cif.req !== 1'b1) begin failures++; $display("FAIL b2b_sb_c1_req got=%h exp=1", cif.req); end
    checks++; if (cif.be !== 4'b0010) begin failures++; $display("FAIL b2b_sb_c1_be got=%b exp=0010", cif.be); end
    checks++; if (cif.wdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL b2b_sb_c1_wdata got=%h exp=a5a5a5a5", cif.wdata); end
    checks++; if (cif.we !== 1'b1) begin failures++; $display("FAIL b2b_sb_c1_we got=%h exp=1", cif.we); end
    next_cycle();
    sample();
    checks++; if (cif.req !== 1'b0) begin failures++; $display("FAIL b2b_done_req got=%h exp=0", cif.req); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_done_stall got=%h exp=0", stall); end
    next_cycle(); st = 1'b0; ld = 1'b1; f3 = 3'b100; baddr = 32'h0000_0003; cif.rdata = 32'hF000_0000;
    sample();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_lbu_c0_stall got=%h exp=1", stall); end
    checks++; if (cif.req !== 1'b0) begin failures++; $display("FAIL b2b_lbu_c0_req got=%h exp=0", cif.req); end
    next_cycle();
    sample();
    checks++; if (cif.req !== 1'b1) begin failures++; $display("FAIL b2b_lbu_c1_req got=%h exp=1", cif.req); end
    checks++; if (cif.we !== 1'b0) begin failures++; $display("FAIL b2b_lbu_c1_we got=%h exp=0", cif.we); end
    next_cycle();
    sample();
    checks++; if (load_data !== 32'h0000_00F0) begin failures++; $display("FAIL b2b_lbu_c2_load_data got=%h exp=000000f0", load_data); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_lbu_c2_stall got=%h exp=0", stall); end
    ld = 1'b0; cif.ready = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    st = 1'b1; f3 = 3'b010; baddr = 32'h0000_0040; sdata = 32'hCAFE_F00D; cif.ready = 1'b0;
    sample();
    next_cycle();
    sample();
    checks++; if (cif.req !== 1'b1) begin failures++; $display("FAIL rmid_pre_req got=%h exp=1", cif.req); end
    #1 reset = 1'b1;
    #1;
    checks++; if (cif.req !== 1'b0) begin failures++; $display("FAIL rmid_req got=%h exp=0", cif.req); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rmid_stall got=%h exp=0", stall); end
    checks++; if (cif.we !== 1'b0) begin failures++; $display("FAIL rmid_we got=%h exp=0", cif.we); end
    next_cycle(); reset = 1'b0; st = 1'b0;
    sample();
    checks++; if (lsu_error !== 1'b0) begin failures++; $display("FAIL rmid_post_error got=%h exp=0", lsu_error); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rmid_post_stall got=%h exp=0", stall); end
    next_cycle(); st = 1'b1; f3 = 3'b010; baddr = 32'h0000_0044; sdata = 32'h1122_3344;
    sample();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sw_c0_stall got=%h exp=1", stall); end
    next_cycle(); cif.ready = 1'b1;
    sample();
    checks++; if (cif.req !== 1'b1) begin failures++; $display("FAIL sw_c1_req got=%h exp=1", cif.req); end
    checks++; if (cif.be !== 4'b1111) begin failures++; $display("FAIL sw_c1_be got=%b exp=1111", cif.be); end
    checks++; if (cif.wdata !== 32'h1122_3344) begin failures++; $display("FAIL sw_c1_wdata got=%h exp=11223344", cif.wdata); end
    checks++; if (cif.address !== 15'h11) begin failures++; $display("FAIL sw_c1_address got=%h exp=11", cif.address); end
    checks++; if (cif.we !== 1'b1) begin failures++; $display("FAIL sw_c1_we got=%h exp=1", cif.we); end
    next_cycle(); cif.ready = 1'b0;
    sample();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sw_c2_stall got=%h exp=0", stall); end
    checks++; if (cif.req !== 1'b0) begin failures++; $display("FAIL sw_c2_req got=%h exp=0", cif.req); end
    checks++; if (lsu_error !== 1'b0) begin failures++; $display("FAIL sw_c2_error got=%h exp=0", lsu_error); end
    st = 1'b0;
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_lhu();
    test_timeout();
    test_abort();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
